// File: rtl/phase_packetizer.sv
// Buffers PR3 phase-estimator beats in a FIFO and serialises each one as an 8-byte packet on a
// valid/ready byte stream. Beats arriving while full are dropped, counted and flagged in-band.
module phase_packetizer #(
  parameter int unsigned DEPTH   = 64,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic                       clk40,
  input  logic                       reset,
  input  logic                       sink_valid,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic [23:0]                sink_freq,
  input  logic [15:0]                sink_phaseA,
  input  logic [15:0]                sink_phaseB,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [15:0]                dropped,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;

  logic [58:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] fill_q, fill_d;
  logic [15:0]   dropped_q;
  logic          gap_pending_q;
  logic [1:0]    state_q;
  logic [2:0]    idx_q;
  logic [63:0]   sreg_q;
  logic          tx_valid_q;

  logic          full, wr_en, drop, hs, pop;
  logic [58:0]   wr_entry, rd_entry;

  always_comb begin
    full     = (fill_q == FW'(DEPTH));
    wr_en    = sink_valid && !full;
    drop     = sink_valid && full;
    hs       = tx_valid_q && tx_ready;
    pop      = (state_q == StSend) && hs && (idx_q == 3'd7);
    wr_entry = {gap_pending_q, sink_sop, sink_eop, sink_freq, sink_phaseA, sink_phaseB};
    rd_entry = mem[rd_ptr_q];
    fill_d   = fill_q;
    unique case ({wr_en, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Storage is not reset; contents are simply ignored once the pointers clear.
  always_ff @(posedge clk40) begin
    if (!reset && wr_en) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      dropped_q     <= '0;
      gap_pending_q <= 1'b0;
      state_q       <= StIdle;
      idx_q         <= '0;
      sreg_q        <= '0;
      tx_valid_q    <= 1'b0;
    end else begin
      fill_q <= fill_d;
      if (wr_en) begin
        wr_ptr_q      <= wr_ptr_q + AW'(1);
        gap_pending_q <= 1'b0;
      end
      if (drop) begin
        gap_pending_q <= 1'b1;
        if (dropped_q != 16'hFFFF) begin
          dropped_q <= dropped_q + 16'd1;
        end
      end
      case (state_q)
        StIdle: begin
          if (fill_q != '0) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          // Header byte is the tag, a zero pad bit, then {gap, sop, eop}; payload follows MSB-first.
          sreg_q     <= {HDR_TAG, 1'b0, rd_entry};
          idx_q      <= '0;
          tx_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (hs) begin
            sreg_q <= {sreg_q[55:0], 8'h00};
            if (idx_q == 3'd7) begin
              rd_ptr_q   <= rd_ptr_q + AW'(1);
              idx_q      <= '0;
              tx_valid_q <= 1'b0;
              state_q    <= (fill_d != '0) ? StLoad : StIdle;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = sreg_q[63:56];
  assign tx_valid = tx_valid_q;
  assign fill     = fill_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_phase_packetizer.sv
// Self-checking bench for phase_packetizer: transaction-level byte scoreboard plus directed
// scenario tasks, all stepping one shared clock-advance routine.
`timescale 1ns/1ps
module tb_phase_packetizer;

  localparam int unsigned TB_DEPTH = 4;
  localparam int unsigned FW       = $clog2(TB_DEPTH) + 1;

  logic          clk40 = 1'b0;
  logic          reset = 1'b1;
  logic          sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [23:0]   sink_freq = '0;
  logic [15:0]   sink_phaseA = '0, sink_phaseB = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [15:0]   dropped;
  logic [FW-1:0] fill;

  phase_packetizer #(.DEPTH(TB_DEPTH), .HDR_TAG(4'hA)) dut (
    .clk40(clk40), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_freq(sink_freq), .sink_phaseA(sink_phaseA),
    .sink_phaseB(sink_phaseB), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dropped(dropped), .fill(fill)
  );

  always #5 clk40 = ~clk40;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a byte queue of every packet owed, and the number of beats still held.
  logic [7:0] exp_q[$];
  int         model_fill = 0;
  int         model_dropped = 0;
  bit         model_gap = 0;
  bit         model_live = 0;
  bit         after_reset = 0;
  bit         stall = 0;
  logic [7:0] stall_data = '0;
  int         pkt_bytes = 0;
  int         rx_count = 0;
  int         hdr_a2 = 0, hdr_a1 = 0, hdr_a0 = 0;
  logic [7:0] last_hdr = '0;
  int         ready_mode = 0;  // 0 hold, 1 random, 2 pattern 1,0,0,1
  int         cyc = 0;

  task automatic observe();
    int fill_reg;
    if (model_live) begin
      vectors++;
      if (fill !== FW'(model_fill)) begin
        miscompares++;
        $display("FAIL fill: got %0d, required %0d (cycle %0d)", fill, model_fill, cyc);
      end
      vectors++;
      if (dropped !== 16'(model_dropped)) begin
        miscompares++;
        $display("FAIL dropped: got %0d, required %0d (cycle %0d)", dropped, model_dropped, cyc);
      end
      if (after_reset) begin
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
          miscompares++;
          $display("FAIL post_reset_tx: got valid=%b data=%h, required 0/00", tx_valid, tx_data);
        end
      end
      vectors++;
      if (tx_valid === 1'b1 && exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_byte: got tx_valid=1 data=%h, required no byte (cycle %0d)",
                 tx_data, cyc);
      end
      if (stall) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b data=%h, required 1/%h", tx_valid, tx_data,
                   stall_data);
        end
      end
    end
    fill_reg = model_fill;
    if (reset) begin
      exp_q.delete();
      model_fill = 0; model_dropped = 0; model_gap = 0; pkt_bytes = 0;
      model_live = 1; after_reset = 1; stall = 0;
    end else if (model_live) begin
      after_reset = 0;
      if (tx_valid === 1'b1 && tx_ready) begin
        rx_count++;
        if (pkt_bytes == 0) begin
          last_hdr = tx_data;
          if (tx_data == 8'hA2) hdr_a2++;
          if (tx_data == 8'hA1) hdr_a1++;
          if (tx_data == 8'hA0) hdr_a0++;
        end
        if (exp_q.size() > 0) begin
          vectors++;
          if (tx_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL tx_byte: got %h, required %h (packet byte %0d, cycle %0d)",
                     tx_data, exp_q[0], pkt_bytes, cyc);
          end
          void'(exp_q.pop_front());
        end
        pkt_bytes++;
        if (pkt_bytes == 8) begin
          pkt_bytes = 0;
          model_fill--;
        end
      end
      if (sink_valid) begin
        if (fill_reg < int'(TB_DEPTH)) begin
          exp_q.push_back({4'hA, 1'b0, model_gap, sink_sop, sink_eop});
          exp_q.push_back(sink_freq[23:16]);
          exp_q.push_back(sink_freq[15:8]);
          exp_q.push_back(sink_freq[7:0]);
          exp_q.push_back(sink_phaseA[15:8]);
          exp_q.push_back(sink_phaseA[7:0]);
          exp_q.push_back(sink_phaseB[15:8]);
          exp_q.push_back(sink_phaseB[7:0]);
          model_gap = 0;
          model_fill++;
        end else begin
          model_gap = 1;
          if (model_dropped < 65535) model_dropped++;
        end
      end
      stall = (tx_valid === 1'b1) && !tx_ready;
      stall_data = tx_data;
    end
  endtask

  task automatic tick();
    @(negedge clk40);
    observe();
    @(posedge clk40);
    #1;
    cyc++;
    if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic [23:0] f,
                           input logic [15:0] pa, input logic [15:0] pb);
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    sink_freq = f; sink_phaseA = pa; sink_phaseB = pb;
    tick();
    sink_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d bytes outstanding tx_valid=%b, required 0 and 0", name,
               exp_q.size(), tx_valid);
    end
  endtask

  task automatic test_reset();
    ready_mode = 0; tx_ready = 1'b1;
    do_reset(5);
    vectors++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || fill !== '0 || dropped !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b data=%h fill=%0d dropped=%0d, required all 0",
               tx_valid, tx_data, fill, dropped);
    end
  endtask

  task automatic test_single_beat();
    logic [7:0] want [8];
    want = '{8'hA2, 8'h12, 8'h34, 8'h56, 8'h80, 8'h01, 8'h7F, 8'hFE};
    tx_ready = 1'b1;
    send_beat(1'b1, 1'b0, 24'h123456, 16'h8001, 16'h7FFE);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (tx_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early: got tx_valid=%b after edge E+%0d, required 0", tx_valid, k);
      end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== want[k]) begin
        miscompares++;
        $display("FAIL single_byte%0d: got valid=%b data=%h, required 1/%h", k, tx_valid,
                 tx_data, want[k]);
      end
      tick();
    end
    vectors++;
    if (fill !== '0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got fill=%0d valid=%b, required 0/0", fill, tx_valid);
    end
  endtask

  task automatic test_backpressure();
    int rx0 = rx_count;
    ready_mode = 2;
    send_beat(1'b1, 1'b0, 24'h123456, 16'h8001, 16'h7FFE);
    drain(200, "backpressure");
    vectors++;
    if (rx_count - rx0 != 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d bytes, required 8", rx_count - rx0);
    end
    ready_mode = 0; tx_ready = 1'b1;
  endtask

  task automatic test_overflow();
    int n = 0;
    do_reset(2);
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      send_beat(1'b0, 1'b0, 24'(i), 16'($urandom), 16'($urandom));
    tick();
    vectors++;
    if (fill !== FW'(4) || dropped !== 16'd3) begin
      miscompares++;
      $display("FAIL overflow_state: got fill=%0d dropped=%0d, required 4/3", fill, dropped);
    end
    tx_ready = 1'b1;
    while (fill === FW'(4) && n < 40) begin tick(); n++; end
    send_beat(1'b0, 1'b0, 24'd7, 16'($urandom), 16'($urandom));
    drain(200, "overflow");
    vectors++;
    if (last_hdr !== 8'hA4) begin
      miscompares++;
      $display("FAIL overflow_gap_hdr: got %h, required A4", last_hdr);
    end
  endtask

  task automatic test_full_collide();
    int n = 0;
    do_reset(2);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_beat(1'b0, 1'b1, 24'($urandom), 16'($urandom), 16'($urandom));
    while (tx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tx_ready = 1'b1;
    repeat (7) tick();
    send_beat(1'b1, 1'b1, 24'hABCDEF, 16'h1111, 16'h2222);
    vectors++;
    if (fill !== FW'(3) || dropped !== 16'd1) begin
      miscompares++;
      $display("FAIL collide_state: got fill=%0d dropped=%0d, required 3/1", fill, dropped);
    end
    drain(200, "collide");
  endtask

  task automatic test_frame();
    do_reset(2);
    hdr_a2 = 0; hdr_a1 = 0; hdr_a0 = 0;
    tx_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      send_beat(i == 0, i == 2047, 24'($urandom), 16'($urandom), 16'($urandom));
      repeat (15) tick();
    end
    drain(100, "frame");
    vectors++;
    if (hdr_a2 != 1 || hdr_a1 != 1 || hdr_a0 != 2046 || dropped !== 16'd0) begin
      miscompares++;
      $display("FAIL frame_headers: got A2=%0d A1=%0d A0=%0d dropped=%0d, required 1/1/2046/0",
               hdr_a2, hdr_a1, hdr_a0, dropped);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0)
        send_beat(1'($urandom), 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
      else
        tick();
    end
    drain(400, "random");
    ready_mode = 0; tx_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int seen = 0;
    do_reset(2);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_beat(1'b0, 1'b0, 24'($urandom), 16'($urandom), 16'($urandom));
    while (tx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (tx_valid !== 1'b0 || fill !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b fill=%0d, required 0/0", tx_valid, fill);
    end
    reset = 1'b0;
    repeat (30) begin
      if (tx_valid !== 1'b0) seen++;
      tick();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: got %0d valid cycles after reset, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_overflow();
    test_full_collide();
    test_back_to_back();
    test_reset_mid();
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_packetizer.md
# phase_packetizer

Downstream stage of the PR3 phase estimator. Captures each valid beat of the PR3 source stream (frequency bin, phase A, phase B, sop/eop markers) into an internal FIFO and serialises each beat as an 8-byte packet on a valid/ready byte stream toward the host link. PR3 has no backpressure, so the block absorbs bursts and drops beats when full. Every drop is counted and flagged in-band.

## Interface
- DEPTH, 64: FIFO entries. Power of two, ≥2.
- HDR_TAG, 4'hA: upper nibble of every header byte.

- clk40 in 1: the single clock (40 MHz); all logic on its rising edge.
- reset in 1: synchronous, active-high.
- sink_valid in 1: beat present; from PR3 source_valid.
- sink_sop in 1: first beat of frame.
- sink_eop in 1: last beat of frame.
- sink_freq in 24: unsigned bin frequency.
- sink_phaseA in 16: signed phase A.
- sink_phaseB in 16: signed phase B.
- tx_data out 8: serial byte.
- tx_valid out 1: tx_data valid.
- tx_ready in 1: consumer accepts byte.
- dropped out 16: count of dropped beats; saturates at 16'hFFFF.
- fill out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO entry, 59 bits: {gap, sop, eop, freq[23:0], phaseA[15:0], phaseB[15:0]}.
- Write rule:
  - If sink_valid=1 and registered fill<DEPTH, write the entry and advance wr_ptr.
  - Otherwise, if sink_valid=1 and fill==DEPTH, drop the beat: set gap_pending=1 and increment dropped (saturating).
  - Fullness uses the registered fill. A pop in the same cycle does not free space for that cycle's write.
- gap bit: the written entry carries gap=gap_pending. gap_pending clears on that write.
- fill: +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
- Read FSM:
  - IDLE: if fill≠0, go to LOAD.
  - LOAD: read mem[rd_ptr] into an 8-byte shift register. Go to SEND with idx=0.
  - SEND: tx_valid=1 and tx_data=byte[idx].
    - On tx_valid&tx_ready with idx<7: idx+1.
    - On the handshake at idx=7: pop (rd_ptr+1). Go to LOAD if fill−1≠0 (fill+0 if a write lands in the same cycle), else IDLE.
- Packet byte order:
  - byte0 = {HDR_TAG, 1'b0, gap, sop, eop}
  - bytes 1–3 = freq[23:16], freq[15:8], freq[7:0]
  - bytes 4–5 = phaseA[15:8], phaseA[7:0]
  - bytes 6–7 = phaseB[15:8], phaseB[7:0]
- Pointers wrap modulo DEPTH.
- Reset:
  - FSM→IDLE; idx, pointers, fill, dropped and gap_pending cleared.
  - tx_valid=0 and tx_data=8'h00 in the cycle after the reset edge.
  - FIFO contents are discarded. A partially sent packet is abandoned, not resumed.
  - While reset=1, sink beats are ignored and not counted.

## Timing
- Beat sampled at edge E into an empty FIFO: fill=1 after E, LOAD after E+1, tx_valid=1 with byte0 after E+2.
- With tx_ready held at 1, one packet takes 8 SEND cycles plus 1 LOAD cycle. Sustained drain is 9 cycles per beat.
- tx_data and tx_valid are registered and change only after a handshake or a state change.
- tx_data must stay stable while tx_valid=1 and tx_ready=0.
- tx_valid never drops without a handshake, except on reset.
- fill and dropped update at the edge that performs the write, drop or pop.

## Test plan
- Reset and single beat:
  - Stimulus: reset for 5 cycles, then one beat: sop=1, eop=0, freq=24'h123456, phaseA=16'h8001, phaseB=16'h7FFE.
  - Response: all outputs 0 during and after reset. tx_valid rises 3 edges after the beat. Bytes are A2,12,34,56,80,01,7F,FE. fill returns to 0.
- Backpressure:
  - Stimulus: same beat; tx_ready toggles 1,0,0,1 repeatedly.
  - Response: each byte held stable while stalled. Byte sequence unchanged. No byte is duplicated or skipped.
- Overflow:
  - Stimulus: DEPTH=4, tx_ready=0, 7 consecutive beats with freq=0..6.
  - Response: beats 0–3 are stored, fill=4, dropped=3.
  - Then raise tx_ready and send one more beat (freq=7). Packets come out for freq 0,1,2,3,7. The freq=7 header has gap=1; all others have gap=0.
- Simultaneous write and pop at full:
  - Stimulus: DEPTH=4, FIFO full; a beat arrives in the same cycle as the idx=7 handshake.
  - Response: the beat is dropped, dropped increments by 1, and fill becomes 3.
- Frame stream:
  - Stimulus: a 2048-beat frame (sop on first, eop on last) at 1 beat per 16 cycles, tx_ready=1.
  - Response: no drops. Header of the first packet is A2, of the last is A1, of the middle packets is A0. Payload matches the input in order.
- Reset mid-packet:
  - Stimulus: assert reset at byte 3 of a packet, with 2 entries queued.
  - Response: tx_valid=0 on the next cycle, fill=0, and no bytes appear after reset deasserts.
